// File: rtl/sdram_responder.sv
// sdram_responder: cycle-accurate far-side model of a 32-bit single-chip SDRAM.
// Decodes the controller's command bus, tracks per-bank row state and tRCD,
// returns read data after the programmed CAS latency and latches the first
// protocol violation it sees.
module sdram_responder #(
    parameter int MEM_ABITS = 12,
    parameter int TRCD      = 2,
    parameter int INIT_CL   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sd_cke,
    input  logic        sd_cs,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    input  logic [1:0]  sd_ba,
    input  logic [10:0] sd_addr,
    input  logic [3:0]  sd_dqm,
    input  logic [31:0] dq_in,
    output logic [31:0] dq_out,
    output logic        dq_oe,
    output logic        init_done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] refresh_cnt
);

    localparam logic [2:0] CMD_LMR   = 3'b000;
    localparam logic [2:0] CMD_REF   = 3'b001;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_BST   = 3'b110;
    localparam logic [2:0] CMD_NOP   = 3'b111;

    localparam logic [3:0] TRCD_LOAD = 4'(TRCD - 1);

    // Backing array; deliberately never cleared so data survives a reset.
    logic [31:0] mem [2**MEM_ABITS];

    logic [3:0]  bank_active_r;
    logic [10:0] bank_row_r [4];
    logic [3:0]  trcd_cnt_r [4];
    logic [1:0]  cl_r;
    logic        init_done_r;
    logic        err_r;
    logic [2:0]  err_code_r;
    logic [15:0] refresh_cnt_r;
    logic [31:0] dq_out_r;
    logic        dq_oe_r;
    logic [2:0]  pipe_valid_r;
    logic [31:0] pipe_data_r [3];

    logic [2:0]  cmd_s;
    logic [20:0] full_idx_s;
    logic [MEM_ABITS-1:0] mem_idx_s;
    logic        all_idle_s;
    logic        mode_ok_s;
    logic [6:0]  flag_s;
    logic [2:0]  code_s;
    logic        do_act_s;
    logic        do_rd_s;
    logic        do_wr_s;
    logic        do_pre_s;
    logic        do_ref_s;
    logic        do_lmr_s;
    logic [1:0]  cl_idx_s;
    logic        unused_bits_s;

    assign full_idx_s    = {sd_ba, bank_row_r[sd_ba], sd_addr[7:0]};
    assign mem_idx_s     = full_idx_s[MEM_ABITS-1:0];
    assign all_idle_s    = (bank_active_r == 4'b0000);
    assign mode_ok_s     = ((sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3)) && (sd_addr[2:0] == 3'b000);
    assign cl_idx_s      = cl_r - 2'd1;
    assign unused_bits_s = ^{sd_addr[3], full_idx_s};

    // A command exists only when the clock is enabled and the chip is selected.
    always_comb begin
        if (sd_cke && !sd_cs) begin
            cmd_s = {sd_ras, sd_cas, sd_we};
        end else begin
            cmd_s = CMD_NOP;
        end
    end

    // Decide which action the command performs and which error conditions it raises.
    always_comb begin
        flag_s   = 7'b0000000;
        do_act_s = 1'b0;
        do_rd_s  = 1'b0;
        do_wr_s  = 1'b0;
        do_pre_s = 1'b0;
        do_ref_s = 1'b0;
        do_lmr_s = 1'b0;
        case (cmd_s)
            CMD_ACT: begin
                flag_s[0] = !init_done_r;
                if (bank_active_r[sd_ba]) begin
                    flag_s[2] = 1'b1;
                end else begin
                    do_act_s = 1'b1;
                end
            end
            CMD_READ, CMD_WRITE: begin
                flag_s[0] = !init_done_r;
                flag_s[6] = (cmd_s == CMD_WRITE) && dq_oe_r;
                if (!bank_active_r[sd_ba]) begin
                    flag_s[3] = 1'b1;
                end else begin
                    flag_s[4] = (trcd_cnt_r[sd_ba] != 4'd0);
                    do_rd_s   = (cmd_s == CMD_READ);
                    do_wr_s   = (cmd_s == CMD_WRITE);
                end
            end
            CMD_PRE: begin
                do_pre_s = 1'b1;
            end
            CMD_REF: begin
                if (all_idle_s) begin
                    do_ref_s = 1'b1;
                end else begin
                    flag_s[5] = 1'b1;
                end
            end
            CMD_LMR: begin
                if (!all_idle_s) begin
                    flag_s[0] = 1'b1;
                end else if (!mode_ok_s) begin
                    flag_s[1] = 1'b1;
                end else begin
                    do_lmr_s = 1'b1;
                end
            end
            CMD_BST: begin
                flag_s[0] = !init_done_r;
            end
            default: begin
                flag_s = 7'b0000000;
            end
        endcase
    end

    // Reduce the raised conditions to a single code; the lowest code wins.
    always_comb begin
        if (flag_s[0]) begin
            code_s = 3'd1;
        end else if (flag_s[1]) begin
            code_s = 3'd2;
        end else if (flag_s[2]) begin
            code_s = 3'd3;
        end else if (flag_s[3]) begin
            code_s = 3'd4;
        end else if (flag_s[4]) begin
            code_s = 3'd5;
        end else if (flag_s[5]) begin
            code_s = 3'd6;
        end else if (flag_s[6]) begin
            code_s = 3'd7;
        end else begin
            code_s = 3'd0;
        end
    end

    // Byte-masked array write; not reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (reset_n && do_wr_s) begin
            for (int i = 0; i < 4; i++) begin
                if (!sd_dqm[i]) begin
                    mem[mem_idx_s][8*i +: 8] <= dq_in[8*i +: 8];
                end
            end
        end
    end

    // Per-bank open/idle state, open row and tRCD countdown.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bank_active_r <= 4'b0000;
            for (int b = 0; b < 4; b++) begin
                bank_row_r[b] <= 11'd0;
                trcd_cnt_r[b] <= 4'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (trcd_cnt_r[b] != 4'd0) begin
                    trcd_cnt_r[b] <= trcd_cnt_r[b] - 4'd1;
                end
            end
            if (do_act_s) begin
                bank_active_r[sd_ba] <= 1'b1;
                bank_row_r[sd_ba]    <= sd_addr;
                trcd_cnt_r[sd_ba]    <= TRCD_LOAD;
            end
            if ((do_rd_s || do_wr_s) && sd_addr[10]) begin
                bank_active_r[sd_ba] <= 1'b0;
            end
            if (do_pre_s) begin
                if (sd_addr[10]) begin
                    bank_active_r <= 4'b0000;
                end else begin
                    bank_active_r[sd_ba] <= 1'b0;
                end
            end
        end
    end

    // Read latency pipeline: a read enters at stage CL-1 and emerges from stage 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pipe_valid_r <= 3'b000;
            for (int s = 0; s < 3; s++) begin
                pipe_data_r[s] <= 32'd0;
            end
            dq_oe_r  <= 1'b0;
            dq_out_r <= 32'd0;
        end else begin
            pipe_valid_r   <= {1'b0, pipe_valid_r[2:1]};
            pipe_data_r[0] <= pipe_data_r[1];
            pipe_data_r[1] <= pipe_data_r[2];
            if (do_rd_s) begin
                pipe_valid_r[cl_idx_s] <= 1'b1;
                pipe_data_r[cl_idx_s]  <= mem[mem_idx_s];
            end
            dq_oe_r <= pipe_valid_r[0];
            if (pipe_valid_r[0]) begin
                dq_out_r <= pipe_data_r[0];
            end
        end
    end

    // Mode register, refresh counter and sticky first-error capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cl_r          <= 2'(INIT_CL);
            init_done_r   <= 1'b0;
            refresh_cnt_r <= 16'd0;
            err_r         <= 1'b0;
            err_code_r    <= 3'd0;
        end else begin
            if (do_lmr_s) begin
                cl_r        <= sd_addr[5:4];
                init_done_r <= 1'b1;
            end
            if (do_ref_s) begin
                refresh_cnt_r <= refresh_cnt_r + 16'd1;
            end
            if (!err_r && (code_s != 3'd0)) begin
                err_r      <= 1'b1;
                err_code_r <= code_s;
            end
        end
    end

    assign dq_out      = dq_out_r;
    assign dq_oe       = dq_oe_r;
    assign init_done   = init_done_r;
    assign err         = err_r;
    assign err_code    = err_code_r;
    assign refresh_cnt = refresh_cnt_r;

endmodule

// File: tb/tb_sdram_responder.sv
// Testbench for sdram_responder: directed command sequences, a behavioural
// memory/protocol model checked every cycle, plus literal expectations.
module tb_sdram_responder;

    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam int TRCD = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sd_cke = 1'b1;
    logic        sd_cs = 1'b1;
    logic        sd_ras = 1'b1;
    logic        sd_cas = 1'b1;
    logic        sd_we = 1'b1;
    logic [1:0]  sd_ba = 2'd0;
    logic [10:0] sd_addr = 11'd0;
    logic [3:0]  sd_dqm = 4'd0;
    logic [31:0] dq_in = 32'd0;
    logic [31:0] dq_out;
    logic        dq_oe;
    logic        init_done;
    logic        err;
    logic [2:0]  err_code;
    logic [15:0] refresh_cnt;

    sdram_responder #(.MEM_ABITS(12), .TRCD(TRCD), .INIT_CL(2)) dut (
        .clk(clk), .reset_n(reset_n), .sd_cke(sd_cke), .sd_cs(sd_cs),
        .sd_ras(sd_ras), .sd_cas(sd_cas), .sd_we(sd_we), .sd_ba(sd_ba),
        .sd_addr(sd_addr), .sd_dqm(sd_dqm), .dq_in(dq_in), .dq_out(dq_out),
        .dq_oe(dq_oe), .init_done(init_done), .err(err), .err_code(err_code),
        .refresh_cnt(refresh_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;
    bit checking = 1'b0;

    // Behavioural model state
    bit          m_init;
    int          m_cl;
    bit          m_err;
    int          m_code;
    int          m_ref;
    bit          m_act [4];
    int          m_row [4];
    int          m_act_edge [4];
    logic [31:0] m_mem [4096];
    bit          exp_oe [4096];
    logic [31:0] exp_dat [4096];
    bit          m_oe;
    logic [31:0] m_dq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic int lowest(input int cur, input int k);
        if (cur == 0 || k < cur) return k;
        return cur;
    endfunction

    function automatic bit any_open();
        return m_act[0] | m_act[1] | m_act[2] | m_act[3];
    endfunction

    // Apply the effect of the inputs present at clock edge edge_n.
    task automatic model_edge();
        int e = edge_n;
        int code = 0;
        int b = int'(sd_ba);
        int idx;
        logic [2:0] c;
        if (!reset_n) begin
            m_init = 1'b0; m_cl = 2; m_err = 1'b0; m_code = 0; m_ref = 0;
            for (int i = 0; i < 4; i++) m_act[i] = 1'b0;
            for (int i = 1; i <= 3; i++) exp_oe[e + i] = 1'b0;
            m_oe = 1'b0; m_dq = 32'd0;
            return;
        end
        c = (sd_cke && !sd_cs) ? {sd_ras, sd_cas, sd_we} : 3'b111;
        case (c)
            C_ACT: begin
                if (!m_init) code = lowest(code, 1);
                if (m_act[b]) code = lowest(code, 3);
                else begin m_act[b] = 1'b1; m_row[b] = int'(sd_addr); m_act_edge[b] = e; end
            end
            C_RD, C_WR: begin
                if (!m_init) code = lowest(code, 1);
                if (c == C_WR && m_oe) code = lowest(code, 7);
                if (!m_act[b]) code = lowest(code, 4);
                else begin
                    if (e - m_act_edge[b] < TRCD) code = lowest(code, 5);
                    idx = (b * 524288 + m_row[b] * 256 + int'(sd_addr[7:0])) % 4096;
                    if (c == C_RD) begin
                        exp_oe[e + m_cl]  = 1'b1;
                        exp_dat[e + m_cl] = m_mem[idx];
                    end else begin
                        for (int i = 0; i < 4; i++)
                            if (!sd_dqm[i]) m_mem[idx][8*i +: 8] = dq_in[8*i +: 8];
                    end
                    if (sd_addr[10]) m_act[b] = 1'b0;
                end
            end
            C_PRE: begin
                if (sd_addr[10]) for (int i = 0; i < 4; i++) m_act[i] = 1'b0;
                else m_act[b] = 1'b0;
            end
            C_REF: begin
                if (any_open()) code = lowest(code, 6);
                else m_ref = (m_ref + 1) % 65536;
            end
            C_LMR: begin
                if (any_open()) code = lowest(code, 1);
                else if (!(sd_addr[6:4] == 3'd2 || sd_addr[6:4] == 3'd3) || sd_addr[2:0] != 3'd0)
                    code = lowest(code, 2);
                else begin m_cl = int'(sd_addr[6:4]); m_init = 1'b1; end
            end
            3'b110: begin
                if (!m_init) code = lowest(code, 1);
            end
            default: begin
            end
        endcase
        if (code != 0 && !m_err) begin m_err = 1'b1; m_code = code; end
        if (exp_oe[e]) begin m_oe = 1'b1; m_dq = exp_dat[e]; exp_oe[e] = 1'b0; end
        else m_oe = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [10:0] addr,
                       input logic [31:0] d, input logic [3:0] dqm);
        sd_cs = 1'b0; {sd_ras, sd_cas, sd_we} = c;
        sd_ba = ba; sd_addr = addr; dq_in = d; sd_dqm = dqm;
        tick();
        sd_cs = 1'b1; {sd_ras, sd_cas, sd_we} = 3'b111;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        nop(2);
        reset_n = 1'b1;
    endtask

    task automatic do_init(input logic [10:0] mode);
        cmd(C_PRE, 2'd0, 11'h400, 32'd0, 4'd0);
        cmd(C_LMR, 2'd0, mode, 32'd0, 4'd0);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checking) begin
            check("dq_oe", {31'd0, dq_oe}, {31'd0, m_oe});
            check("dq_out", dq_out, m_dq);
            check("init_done", {31'd0, init_done}, {31'd0, m_init});
            check("err", {31'd0, err}, {31'd0, m_err});
            check("err_code", {29'd0, err_code}, m_code);
            check("refresh_cnt", {16'd0, refresh_cnt}, m_ref);
        end
    end

    initial begin
        reset_n = 1'b0;
        tick();
        checking = 1'b1;
        tick();
        reset_n = 1'b1;
        check("lit_reset_init", {31'd0, init_done}, 32'd0);
        check("lit_reset_err", {31'd0, err}, 32'd0);
        check("lit_reset_oe", {31'd0, dq_oe}, 32'd0);

        // init with CL=2
        do_init(11'h220);
        check("lit_init_done", {31'd0, init_done}, 32'd1);

        // write with auto-precharge, reopen, read back
        cmd(C_ACT, 2'd1, 11'h155, 32'd0, 4'd0);
        nop(1);
        cmd(C_WR, 2'd1, 11'h412, 32'hDEADBEEF, 4'b0000);
        nop(2);
        cmd(C_ACT, 2'd1, 11'h155, 32'd0, 4'd0);
        nop(1);
        cmd(C_RD, 2'd1, 11'h012, 32'd0, 4'd0);
        nop(1);
        check("lit_rd_oe_early", {31'd0, dq_oe}, 32'd0);
        nop(1);
        check("lit_rd_oe", {31'd0, dq_oe}, 32'd1);
        check("lit_rd_data", dq_out, 32'hDEADBEEF);
        nop(1);
        check("lit_rd_oe_once", {31'd0, dq_oe}, 32'd0);

        // byte-masked write
        cmd(C_WR, 2'd1, 11'h012, 32'h11223344, 4'b0011);
        nop(1);
        cmd(C_RD, 2'd1, 11'h012, 32'd0, 4'd0);
        nop(2);
        check("lit_mask_data", dq_out, 32'h1122BEEF);
        nop(1);

        // fully masked write changes nothing
        cmd(C_WR, 2'd1, 11'h012, 32'hFFFFFFFF, 4'b1111);
        nop(1);
        cmd(C_RD, 2'd1, 11'h012, 32'd0, 4'd0);
        nop(2);
        check("lit_fullmask_data", dq_out, 32'h1122BEEF);
        check("lit_fullmask_err", {31'd0, err}, 32'd0);
        nop(1);

        // CL=3 back-to-back reads
        cmd(C_WR, 2'd1, 11'h00A, 32'hA0A0A0A0, 4'd0);
        cmd(C_WR, 2'd1, 11'h00B, 32'hB1B1B1B1, 4'd0);
        cmd(C_WR, 2'd1, 11'h00C, 32'hC2C2C2C2, 4'd0);
        nop(1);
        do_init(11'h230);
        cmd(C_ACT, 2'd1, 11'h155, 32'd0, 4'd0);
        nop(1);
        cmd(C_RD, 2'd1, 11'h00A, 32'd0, 4'd0);
        cmd(C_RD, 2'd1, 11'h00B, 32'd0, 4'd0);
        cmd(C_RD, 2'd1, 11'h00C, 32'd0, 4'd0);
        check("lit_cl3_not_yet", {31'd0, dq_oe}, 32'd0);
        nop(1);
        check("lit_cl3_a", dq_out, 32'hA0A0A0A0);
        nop(1);
        check("lit_cl3_b", dq_out, 32'hB1B1B1B1);
        nop(1);
        check("lit_cl3_c", dq_out, 32'hC2C2C2C2);
        check("lit_cl3_oe", {31'd0, dq_oe}, 32'd1);
        nop(1);

        // refresh
        cmd(C_PRE, 2'd0, 11'h400, 32'd0, 4'd0);
        for (int i = 0; i < 3; i++) cmd(C_REF, 2'd0, 11'd0, 32'd0, 4'd0);
        check("lit_ref3", {16'd0, refresh_cnt}, 32'd3);
        cmd(C_ACT, 2'd2, 11'h005, 32'd0, 4'd0);
        cmd(C_REF, 2'd0, 11'd0, 32'd0, 4'd0);
        check("lit_ref_err", {29'd0, err_code}, 32'd6);
        check("lit_ref_hold", {16'd0, refresh_cnt}, 32'd3);

        // read to an idle bank
        do_reset();
        do_init(11'h220);
        cmd(C_RD, 2'd0, 11'h000, 32'd0, 4'd0);
        nop(3);
        check("lit_idle_err", {31'd0, err}, 32'd1);
        check("lit_idle_code", {29'd0, err_code}, 32'd4);

        // tRCD violation; array survives reset
        do_reset();
        do_init(11'h220);
        cmd(C_ACT, 2'd1, 11'h155, 32'd0, 4'd0);
        cmd(C_RD, 2'd1, 11'h012, 32'd0, 4'd0);
        check("lit_trcd_code", {29'd0, err_code}, 32'd5);
        nop(2);
        check("lit_trcd_data", dq_out, 32'h1122BEEF);
        nop(1);

        // reset in the middle of a read
        do_reset();
        do_init(11'h220);
        cmd(C_ACT, 2'd1, 11'h155, 32'd0, 4'd0);
        nop(1);
        cmd(C_RD, 2'd1, 11'h012, 32'd0, 4'd0);
        reset_n = 1'b0;
        nop(1);
        check("lit_midrst_oe1", {31'd0, dq_oe}, 32'd0);
        nop(1);
        reset_n = 1'b1;
        check("lit_midrst_oe2", {31'd0, dq_oe}, 32'd0);
        nop(2);

        // bus conflict: write while read data is on the bus
        do_init(11'h220);
        cmd(C_ACT, 2'd1, 11'h155, 32'd0, 4'd0);
        nop(1);
        cmd(C_RD, 2'd1, 11'h012, 32'd0, 4'd0);
        nop(2);
        cmd(C_WR, 2'd1, 11'h013, 32'h5A5A0F0F, 4'd0);
        check("lit_conflict_code", {29'd0, err_code}, 32'd7);
        nop(2);
        cmd(C_RD, 2'd1, 11'h013, 32'd0, 4'd0);
        nop(2);
        check("lit_conflict_data", dq_out, 32'h5A5A0F0F);
        nop(1);

        // illegal mode
        do_reset();
        cmd(C_LMR, 2'd0, 11'h240, 32'd0, 4'd0);
        check("lit_mode_code", {29'd0, err_code}, 32'd2);
        check("lit_mode_init", {31'd0, init_done}, 32'd0);
        nop(2);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Cycle-accurate responder model for the 32-bit single-chip SDRAM on the Tang Nano 20k.
- Sits on the far side of the SDRAM pins and decodes the command/address/DQM bus issued by the SDRAM controller.
- Keeps per-bank row state and returns read data after the programmed CAS latency.
- Flags protocol violations. Used as the memory in controller testbenches, and optionally in FPGA self-check builds with a reduced array.

Parameters:
- MEM_ABITS, 12, number of low bits of the linear word index {ba,row,col} that select a backing-array word. Higher index bits alias.
- TRCD, 2, minimum cycles from ACTIVE to READ/WRITE on the same bank.
- INIT_CL, 2, CAS latency used before the first LOAD_MODE.

Ports:
- clk  in  1  SDRAM clock; all sampling on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- sd_cke  in  1  clock enable; commands ignored when 0.
- sd_cs  in  1  chip select, active low.
- sd_ras  in  1  row address strobe, active low.
- sd_cas  in  1  column address strobe, active low.
- sd_we  in  1  write enable, active low.
- sd_ba  in  2  bank address.
- sd_addr  in  11  multiplexed address: row [10:0], column [7:0], A10 auto-precharge/all-banks.
- sd_dqm  in  4  byte masks, bit i masks dq[8i+7:8i].
- dq_in  in  32  data from controller.
- dq_out  out  32  read data.
- dq_oe  out  1  responder drives the data bus.
- init_done  out  1  a valid LOAD_MODE has been accepted.
- err  out  1  sticky protocol error.
- err_code  out  3  code of the first error.
- refresh_cnt  out  16  number of AUTO_REFRESH commands accepted; wraps.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - dq_out=0, dq_oe=0, init_done=0, err=0, err_code=0, refresh_cnt=0.
  - All banks idle; read pipeline flushed; CL=INIT_CL.
  - Array contents are not cleared.
  - A reset mid-read cancels pending data.
- Command decode: only when sd_cke=1 and sd_cs=0, from {ras,cas,we}.
  - 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO_REFRESH, 000 LOAD_MODE, 110 BURST_TERMINATE (accepted, no effect).
- LOAD_MODE:
  - Requires all banks idle, else error 1.
  - addr[6:4] must be 2 or 3, and addr[2:0] must be 000 (burst length 1); otherwise error 2 and mode unchanged.
  - On success: CL=addr[6:4] and init_done=1.
- ACTIVE:
  - Bank sd_ba must be idle, else error 3.
  - Stores row=sd_addr and sets the bank active.
  - Loads the bank tRCD counter with TRCD-1, which decrements to 0.
- READ/WRITE:
  - Bank must be active, else error 4 and the command is ignored.
  - Bank tRCD counter must be 0, else error 5; the access still executes.
  - Column = sd_addr[7:0]; word index = {ba,row,col} truncated to MEM_ABITS.
  - If sd_addr[10]=1 the bank goes idle at the next edge (auto-precharge).
- WRITE:
  - dq_in sampled at the command edge.
  - Byte i written only if sd_dqm[i]=0.
  - sd_dqm=1111 writes nothing and raises no error.
- READ:
  - Array word captured at the command edge into a 3-deep pipeline tagged with CL.
  - dq_oe=1 and dq_out=word for exactly one cycle, starting CL clock edges after the command edge.
  - Otherwise dq_oe=0 and dq_out holds its last value.
  - Reads may issue back-to-back every cycle; each emerges in order.
  - Read DQM is ignored.
  - Read-after-write to the same word returns the new data.
- PRECHARGE:
  - sd_addr[10]=1 idles all banks; otherwise idles bank sd_ba.
  - Precharging an idle bank is legal.
- AUTO_REFRESH:
  - Requires all banks idle, else error 6 and the command is ignored.
  - Otherwise refresh_cnt increments.
- Bus conflict: a WRITE command on an edge where dq_oe=1 gives error 7; the write still executes.
- Any command other than NOP, PRECHARGE, AUTO_REFRESH or LOAD_MODE before init_done gives error 1.
- Error reporting:
  - err sets on the first error; err_code latches that first code.
  - Both are held until reset.
  - Simultaneous conditions: the lowest code wins.

Test Plan:
- Init: reset, PRECHARGE with A10=1, LOAD_MODE addr=0x220 → init_done=1, CL=2, err=0.
- Write/read: ACTIVE ba=1 row=0x155; 2 cycles later WRITE col=0x12 A10=1 dq_in=0xDEADBEEF dqm=0000; ACTIVE again; READ col=0x12 → dq_oe high exactly 2 edges after READ with dq_out=0xDEADBEEF.
- Byte mask: over 0xDEADBEEF, WRITE dq_in=0x11223344 dqm=0011 → read returns 0x1122BEEF.
- CL=3 back-to-back: LOAD_MODE addr=0x230; READs of 0xA,0xB,0xC on consecutive cycles → three consecutive dq_oe cycles starting 3 edges after the first READ, data in order.
- Violations: READ to an idle bank → err=1, err_code=4, dq_oe stays 0. After reset, READ 1 cycle after ACTIVE → err_code=5.
- Refresh: 3 AUTO_REFRESH with all banks idle → refresh_cnt=3. AUTO_REFRESH with bank 2 open → err_code=6, count unchanged. Reset mid-READ → no dq_oe pulse.
